// File: rtl/mem_access_unit.sv
// M-stage memory access unit: one bus transaction per load/store, stalling the pipeline until done.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ValidM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | no transaction; an access presented here is latched or rejected
    // BUSY  | bus request outstanding, waiting for mem_ack
    // DONE  | result/error presented for one cycle, pipeline released
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] resultQ;
    logic        weQ;
    logic        errQ;
    logic        access;
    logic        aligned;
    logic        timeoutHit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    assign access  = ValidM & (MemReadM | MemWriteM);
    assign aligned = (ALUOutM[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmoCnt;

    // Expiry fires in the BUSY cycle that would bring the count to TIMEOUT_CYCLES; ack wins.
    assign timeoutHit = (state == BUSY) && !mem_ack
                        && (tmoCnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmoCnt <= '0;
        end else if (state != BUSY) begin
            tmoCnt <= '0;
        end else if (!mem_ack) begin
            tmoCnt <= tmoCnt + 8'd1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        StallM    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    StallM    = 1'b1;
                    stateNext = aligned ? BUSY : DONE;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (mem_ack || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addrQ   <= '0;
            wdataQ  <= '0;
            weQ     <= 1'b0;
            resultQ <= '0;
            errQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            addrQ  <= {ALUOutM[31:2], 2'b00};
                            wdataQ <= WriteDataM;
                            weQ    <= MemWriteM;
                            errQ   <= 1'b0;
                        end else begin
                            errQ    <= 1'b1;
                            resultQ <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (!weQ) begin
                            resultQ <= mem_rdata;
                        end
                    end else if (timeoutHit) begin
                        errQ    <= 1'b1;
                        resultQ <= '0;
                    end
                end
                DONE: begin
                    errQ <= 1'b0;
                end
                default: begin
                    errQ <= 1'b0;
                end
            endcase
        end
    end

    // Bus side is purely registered so it cannot glitch with pipeline inputs.
    assign mem_req   = (state == BUSY);
    assign mem_we    = (state == BUSY) & weQ;
    assign mem_addr  = addrQ;
    assign mem_wdata = wdataQ;
    assign ReadDataM = resultQ;
    assign ErrM      = (state == DONE) & errQ;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, range 1..255: BUSY cycles without mem_ack before abort (MEM_TIMEOUT_EN only).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ValidM  input  1  instruction in M stage is valid.
REQ-005 SHALL have port MemReadM  input  1  load request.
REQ-006 SHALL have port MemWriteM  input  1  store request.
REQ-007 SHALL have port ALUOutM  input  32  effective byte address.
REQ-008 SHALL have port WriteDataM  input  32  store data.
REQ-009 SHALL have port ReadDataM  output  32  load result, sampled by the M/W register.
REQ-010 SHALL have port StallM  output  1  freeze F/D/E/M stages and the M/W register.
REQ-011 SHALL have port ErrM  output  1  access fault, one-cycle pulse.
REQ-012 SHALL have port mem_req  output  1  bus request.
REQ-013 SHALL have port mem_we  output  1  bus write enable.
REQ-014 SHALL have port mem_addr  output  32  bus word address (byte address, bits [1:0] = 0).
REQ-015 SHALL have port mem_wdata  output  32  bus write data.
REQ-016 SHALL have port mem_ack  input  1  bus completion, one cycle.
REQ-017 SHALL have port mem_rdata  input  32  bus read data, valid with mem_ack.

Function
REQ-018 SHALL define access = ValidM & (MemReadM | MemWriteM); MemWriteM has priority when both are set (treated as store).
REQ-019 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-020 IDLE, no access: StallM=0, mem_req=0, ReadDataM holds last value, stay IDLE.
REQ-021 IDLE, access with ALUOutM[1:0]==0: StallM=1; at the edge latch address, data and we, then go to BUSY.
REQ-022 IDLE, access with ALUOutM[1:0]!=0: StallM=1, no bus request; go to DONE with the error flag set and the result register set to 0.
REQ-023 BUSY: mem_req=1 and StallM=1; mem_addr, mem_wdata and mem_we SHALL be driven from the latched values, constant for the whole request.
REQ-024 BUSY with mem_ack=1: at the edge capture mem_rdata into the result register (loads only; stores leave it unchanged), then go to DONE.
REQ-025 DONE: StallM=0, mem_req=0, ReadDataM=result register, ErrM=error flag; next edge go to IDLE and clear the error flag.
REQ-026 Minimum aligned access SHALL occupy M for 3 cycles (IDLE, BUSY, DONE) with ack in the first BUSY cycle; misaligned SHALL occupy 2 cycles.
REQ-027 mem_ack in IDLE or DONE SHALL be ignored.
REQ-028 Outputs SHALL be glitch-free functions of state and inputs; mem_req, mem_we, mem_addr and mem_wdata SHALL depend on state only.

Reset
REQ-029 RST=1 SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, ErrM=0, StallM=0 (the last only when no access is presented), error flag=0 and timeout counter=0.
REQ-030 RST asserted during BUSY SHALL abandon the bus transaction; a mem_ack arriving after release SHALL be ignored.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-032 Under MEM_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES without ack, the FSM SHALL go to DONE with the error flag set and the result register set to 0; mem_req SHALL drop.
REQ-033 Under MEM_TIMEOUT_EN, ack in the same cycle the count expires SHALL win (normal completion).
REQ-034 Without MEM_TIMEOUT_EN: no counter; BUSY SHALL wait indefinitely; ErrM SHALL only signal misalignment.

Verification
REQ-035 Load 0x0000_0010, ack in the first BUSY cycle with rdata 0xDEAD_BEEF -> StallM high for 2 cycles, ReadDataM=0xDEAD_BEEF in DONE, ErrM=0.
REQ-036 Store 0x1234_5678 to 0x0000_0020, ack after 4 cycles -> mem_we=1, mem_addr and mem_wdata stable for 4 cycles, ReadDataM unchanged.
REQ-037 Load 0x0000_0013 (misaligned) -> mem_req never asserted, one stall cycle, ErrM=1 for one cycle, ReadDataM=0.
REQ-038 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> mem_req high for exactly 4 cycles, then DONE with ErrM=1 and ReadDataM=0; without the macro, mem_req stays high for 100+ cycles.
REQ-039 RST pulsed in BUSY, then ack 2 cycles later -> IDLE, mem_req=0, ack ignored, ReadDataM=0.
REQ-040 Back-to-back loads 0x4 then 0x8, each acked immediately -> two full IDLE-BUSY-DONE sequences, with the correct data each in its DONE cycle.
